// File: rtl/dma_pkg.sv
// Shared types and span arithmetic for the DMA read/write sequencers.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_DATA,
    ST_FLUSH,
    ST_WAIT_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         LEN_W     = 5;
  localparam int         WORDS_W   = 4;

  // Number of 32-bit words touched by len bytes starting at byte offset off: 1..9.
  function automatic logic [WORDS_W-1:0] word_count(input logic [1:0]       off,
                                                    input logic [LEN_W-1:0] len);
    logic [5:0] bytes_up;
    bytes_up = 6'(off) + 6'(len) + 6'd3;
    return bytes_up[5:2];
  endfunction

endpackage

// File: rtl/dma_span_calc.sv
// Combinational span of an unaligned transfer: aligned start, word count, empty flag.
module dma_span_calc
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   len,
  output logic [ADDR_W-1:0]  start_addr,
  output logic [WORDS_W-1:0] words,
  output logic               zero_len
);

  assign start_addr = {addr[ADDR_W-1:2], 2'b00};
  assign words      = word_count(addr[1:0], len);
  assign zero_len   = (len == '0);

endmodule

// File: rtl/dma_read_sequencer.sv
// Sequences one unaligned DMA read as single-beat AXI4-Lite reads feeding a byte aligner,
// then drains the aligner with a flush beat and waits for its completion.
module dma_read_sequencer
  import dma_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              aln_start,
  output logic [ADDR_W-1:0] aln_address,
  output logic [LEN_W-1:0]  aln_length,
  output logic              aln_data_valid,
  output logic [DATA_W-1:0] aln_rd_data,
  input  logic              aln_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dma_read_sequencer: DATA_W must be 32, the aligner is 32-bit");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  span_start, start_addr_q;
  logic [WORDS_W-1:0] span_words, words_q, beat_cnt_q;
  logic               span_zero;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               tmo_hit, accept, waiting;
  logic               finish_ok, finish_err, beat_take;

  dma_span_calc #(.ADDR_W(ADDR_W)) u_span (
    .addr       (cmd_addr),
    .len        (cmd_len),
    .start_addr (span_start),
    .words      (span_words),
    .zero_len   (span_zero)
  );

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign waiting = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_WAIT_DONE);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational process gets a default first; a missing
  // branch would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    beat_take  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (span_zero) finish_ok = 1'b1;
          else           state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_ADDR;
      ST_ADDR: begin
        if (arready) begin
          state_d = ST_DATA;
        end else if (tmo_hit) begin
          finish_err = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          if (rresp == RESP_OKAY) begin
            beat_take = 1'b1;
            state_d   = (beat_cnt_q + WORDS_W'(1) == words_q) ? ST_FLUSH : ST_ADDR;
          end else begin
            finish_err = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (tmo_hit) begin
          finish_err = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_FLUSH: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (aln_done) begin
          finish_ok = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          finish_err = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake strobes decode straight from state so a reset drops them without a clock.
  always_comb begin
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    aln_start = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_START: aln_start = 1'b1;
      ST_ADDR:  arvalid   = 1'b1;
      ST_DATA:  rready    = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done           <= 1'b0;
      err            <= 1'b0;
      aln_data_valid <= 1'b0;
      aln_rd_data    <= '0;
      aln_address    <= '0;
      aln_length     <= '0;
      words_q        <= '0;
      start_addr_q   <= '0;
      araddr         <= '0;
      beat_cnt_q     <= '0;
    end else begin
      done           <= finish_ok | finish_err;
      err            <= finish_err;
      aln_data_valid <= beat_take | (state_q == ST_FLUSH);
      if (beat_take)                aln_rd_data <= rdata;
      else if (state_q == ST_FLUSH) aln_rd_data <= '0;
      if (accept) begin
        aln_address  <= cmd_addr;
        aln_length   <= cmd_len;
        words_q      <= span_words;
        start_addr_q <= span_start;
      end
      if (state_q == ST_START) begin
        araddr     <= start_addr_q;
        beat_cnt_q <= '0;
      end else if (beat_take) begin
        araddr     <= araddr + ADDR_W'(4);
        beat_cnt_q <= beat_cnt_q + WORDS_W'(1);
      end
    end
  end

  // One counter serves all wait states; it restarts whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tmo_cnt_q <= '0;
    else if (state_d != state_q) tmo_cnt_q <= '0;
    else if (waiting)            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

endmodule
